alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Command sequencer directly upstream of ALU_2.
- Accepts one parallel operation (op, operands) on a valid/ready handshake.
- Drives ALU_2's Begin/RST/op/inbus pins in the required byte-serial order, waits a fixed per-op latency, and samples outbus into a parallel result.
- Returns the result on a valid/ready handshake; frees the host from ALU_2 pin timing.

Parameters:
- BYTE_CYC, 2, cycles each operand byte is held on alu_inbus (min 1)
- LAT_AS, 8, cycles from last operand byte to first result sample for add/sub (min 1)
- LAT_MUL, 80, same for multiply (min 1)
- LAT_DIV, 80, same for divide (min 1)
- OUT_CYC, 1, cycles between first and second result-byte samples (min 1)

Ports:
- CLk  in  1  clock, rising edge
- RST  in  1  synchronous active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0 add, 1 sub, 2 mul, 3 div
- cmd_a  in  16  operand A; div uses all 16 bits as dividend, others use [7:0]
- cmd_b  in  8  operand B / divisor
- res_valid  out  1  result valid
- res_ready  in  1  host accepts result
- res_data  out  16  result: {first captured byte, second}; add/sub: {8'h00, byte}
- alu_begin  out  1  to ALU_2 Begin
- alu_rst  out  1  to ALU_2 RST
- alu_op  out  2  to ALU_2 op
- alu_inbus  out  8  to ALU_2 inbus
- alu_outbus  in  8  from ALU_2 outbus

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all outputs 0, state IDLE, counters 0. RST mid-operation aborts immediately: alu_begin/alu_rst drop to 0 the next cycle, any captured result is discarded, res_valid=0.
- cmd_ready = (state==IDLE); it is 1 the cycle after RST deasserts.
- Handshake: a transfer occurs when valid&ready are both high at a rising edge. cmd_op/a/b are latched on accept. res_data is held stable while res_valid=1 and res_ready=0.
- States: IDLE -> ARST -> LOAD -> WAIT -> CAPT -> GAP -> RESP -> IDLE.
  - IDLE: alu_begin=0, alu_inbus=0; on accept -> ARST.
  - ARST, 1 cycle: alu_begin=1, alu_rst=1, alu_op=latched op, alu_inbus=0.
  - LOAD: alu_begin=1, alu_rst=0. Byte sequence, each held BYTE_CYC cycles:
    - add/sub/mul: A[7:0], B.
    - div: A[15:8], A[7:0], B.
    - Then -> WAIT.
  - WAIT: hold alu_inbus=last byte and alu_begin=1 for LAT (selected by op) cycles.
  - CAPT: on the last WAIT cycle edge, sample alu_outbus as byte0.
    - add/sub: result = {8'h00, byte0}, -> GAP.
    - mul/div: after a further OUT_CYC cycles sample byte1; result = {byte0, byte1}; -> GAP.
  - GAP, 1 cycle: alu_begin=0, alu_op held, alu_inbus=0. Ends the ALU_2 operation.
  - RESP: res_valid=1 until res_ready; then -> IDLE. No new command is accepted while res_valid=1.
- Latency, accept to res_valid (ARST + bytes + latency + capture + GAP):
  - add/sub: 1 + 2*BYTE_CYC + LAT_AS + 1 cycles.
  - mul: 1 + 2*BYTE_CYC + LAT_MUL + OUT_CYC + 1.
  - div: 1 + 3*BYTE_CYC + LAT_DIV + OUT_CYC + 1.
  - Defaults: add 14, mul 87, div 89.
- Counters sized for the largest parameter. No wrap is permitted; counters reload on each state entry.
- Byte order of ALU_2 outputs is fixed:
  - mul: product high then low.
  - div: remainder then quotient.
- cmd_valid asserted in the same cycle res_ready completes RESP is not accepted; it is accepted in the following IDLE cycle.

Test Plan:
- Add: RST 1 cycle, then cmd op=0 A=24 B=31 -> alu_rst pulse 1 cycle, inbus 24 then 31 for 2 cycles each; res_data=16'h0037 exactly 14 cycles after accept; cmd_ready=0 throughout.
- Sub: op=1 A=99 B=55 -> res_data=16'h002C; alu_op=1 from ARST through GAP; alu_begin low exactly 1 cycle (GAP) before res_valid.
- Mul: op=2 A=32 B=25 -> res_data=16'h0320 (800); res_valid at accept+87.
- Div: op=3 A=16'h0999 B=25 -> inbus sequence 0x09, 0x99, 0x19; res_data=16'h0762 (rem 7, quot 98).
- Backpressure: hold res_ready=0 for 20 cycles after the add result -> res_data stable, cmd_valid ignored; release -> IDLE next cycle, the pending command is accepted one cycle later.
- Reset mid-mul, in WAIT -> next cycle alu_begin=0, alu_rst=0, res_valid=0, cmd_ready=1 the cycle after RST falls; a fresh add still returns 16'h0037.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Host command/result handshakes plus the ALU_2 pin bundle driven by the sequencer.
interface alu_seq_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_a;
   logic [7:0]  cmd_b;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        alu_begin;
   logic        alu_rst;
   logic [1:0]  alu_op;
   logic [7:0]  alu_inbus;
   logic [7:0]  alu_outbus;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, alu_outbus,
      input  cmd_ready, res_valid, res_data, alu_begin, alu_rst, alu_op, alu_inbus
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, alu_outbus,
      output cmd_ready, res_valid, res_data, alu_begin, alu_rst, alu_op, alu_inbus
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer that turns one parallel ALU command into ALU_2's byte-serial pin protocol
// and returns the sampled result bytes as a single parallel word.
module alu_seq_ctrl #(
   parameter int BYTE_CYC = 2,
   parameter int LAT_AS   = 8,
   parameter int LAT_MUL  = 80,
   parameter int LAT_DIV  = 80,
   parameter int OUT_CYC  = 1
) (
   input logic         CLk,
   input logic         RST,
   alu_seq_ctrl_if.slave bus
);

   localparam int MAX_AB  = (LAT_AS > BYTE_CYC) ? LAT_AS : BYTE_CYC;
   localparam int MAX_MD  = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
   localparam int MAX_ABM = (MAX_AB > MAX_MD) ? MAX_AB : MAX_MD;
   localparam int MAX_CYC = (MAX_ABM > OUT_CYC) ? MAX_ABM : OUT_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] BYTE_LD = CNT_W'(BYTE_CYC - 1);
   localparam logic [CNT_W-1:0] OUT_LD  = CNT_W'(OUT_CYC - 1);

   typedef enum logic [2:0] {IDLE, ARST, LOAD, WAIT, CAPT, GAP, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       bidx;
   logic [1:0]       op_q;
   logic [15:0]      a_q;
   logic [7:0]       b_q;
   logic [7:0]       byte0;

   // Divide streams the full 16-bit dividend, so it has one extra leading byte.
   function automatic logic [7:0] byte_sel(input logic [1:0] op, input logic [15:0] a,
                                           input logic [7:0] b, input logic [1:0] idx);
      logic [7:0] v;
      v = b;
      if (op == 2'd3) begin
         if (idx == 2'd0)      v = a[15:8];
         else if (idx == 2'd1) v = a[7:0];
      end else if (idx == 2'd0) begin
         v = a[7:0];
      end
      return v;
   endfunction

   function automatic logic [1:0] last_idx(input logic [1:0] op);
      return (op == 2'd3) ? 2'd2 : 2'd1;
   endfunction

   function automatic logic [CNT_W-1:0] lat_ld(input logic [1:0] op);
      logic [CNT_W-1:0] v;
      case (op)
         2'd2:    v = CNT_W'(LAT_MUL - 1);
         2'd3:    v = CNT_W'(LAT_DIV - 1);
         default: v = CNT_W'(LAT_AS - 1);
      endcase
      return v;
   endfunction

   always_ff @(posedge CLk) begin
      if (RST) begin
         state         <= IDLE;
         cnt           <= '0;
         bidx          <= '0;
         bus.cmd_ready <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.alu_begin <= 1'b0;
         bus.alu_rst   <= 1'b0;
         bus.alu_op    <= '0;
         bus.alu_inbus <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  op_q          <= bus.cmd_op;
                  a_q           <= bus.cmd_a;
                  b_q           <= bus.cmd_b;
                  state         <= ARST;
                  bus.cmd_ready <= 1'b0;
                  bus.alu_begin <= 1'b1;
                  bus.alu_rst   <= 1'b1;
                  bus.alu_op    <= bus.cmd_op;
                  bus.alu_inbus <= '0;
               end else begin
                  bus.cmd_ready <= 1'b1;
               end
            end
            ARST: begin
               bus.alu_rst   <= 1'b0;
               state         <= LOAD;
               bidx          <= '0;
               cnt           <= BYTE_LD;
               bus.alu_inbus <= byte_sel(op_q, a_q, b_q, 2'd0);
            end
            LOAD: begin
               if (cnt == '0) begin
                  if (bidx == last_idx(op_q)) begin
                     state <= WAIT;
                     cnt   <= lat_ld(op_q);
                  end else begin
                     bidx          <= bidx + 2'd1;
                     cnt           <= BYTE_LD;
                     bus.alu_inbus <= byte_sel(op_q, a_q, b_q, bidx + 2'd1);
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  if (op_q[1]) begin
                     byte0 <= bus.alu_outbus;
                     state <= CAPT;
                     cnt   <= OUT_LD;
                  end else begin
                     bus.res_data  <= {8'h00, bus.alu_outbus};
                     state         <= GAP;
                     bus.alu_begin <= 1'b0;
                     bus.alu_inbus <= '0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CAPT: begin
               if (cnt == '0) begin
                  bus.res_data  <= {byte0, bus.alu_outbus};
                  state         <= GAP;
                  bus.alu_begin <= 1'b0;
                  bus.alu_inbus <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               state         <= RESP;
               bus.res_valid <= 1'b1;
            end
            RESP: begin
               // The completing cycle only returns to IDLE; the next command waits one more edge.
               if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomised bench for alu_seq_ctrl: a timeline model of the ALU_2 pin protocol plus an ALU_2 stand-in.
module tb_alu_seq_ctrl;

   localparam int BC  = 2;
   localparam int LAS = 8;
   localparam int LMU = 80;
   localparam int LDV = 80;
   localparam int OC  = 1;

   localparam int PH_OFF  = 0;
   localparam int PH_NR   = 1;
   localparam int PH_IDLE = 2;
   localparam int PH_BUSY = 3;
   localparam int PH_RESP = 4;

   logic clk;
   logic rst;
   alu_seq_ctrl_if bus ();

   alu_seq_ctrl #(.BYTE_CYC(BC), .LAT_AS(LAS), .LAT_MUL(LMU), .LAT_DIV(LDV), .OUT_CYC(OC)) dut (
      .CLk(clk),
      .RST(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int rr_mode = 2;

   int          m_phase = PH_OFF;
   int          m_t = 0;
   logic [1:0]  m_op = '0;
   logic [15:0] m_a = '0;
   logic [7:0]  m_b = '0;
   logic [15:0] m_res = '0;
   logic [1:0]  m_alu_op = '0;
   int          m_acc_cnt = 0;
   int          m_acc_cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int f_nb(input logic [1:0] op);
      return (op == 2'd3) ? 3 : 2;
   endfunction

   function automatic int f_lat(input logic [1:0] op);
      return (op < 2'd2) ? LAS : ((op == 2'd2) ? LMU : LDV);
   endfunction

   function automatic int f_total(input logic [1:0] op);
      return 1 + f_nb(op) * BC + f_lat(op) + ((op >= 2'd2) ? OC : 0) + 1;
   endfunction

   function automatic logic [15:0] f_res(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b);
      logic [7:0]  s;
      logic [15:0] q;
      logic [15:0] r;
      case (op)
         2'd0: begin s = a[7:0] + b; return {8'h00, s}; end
         2'd1: begin s = a[7:0] - b; return {8'h00, s}; end
         2'd2: return {8'h00, a[7:0]} * {8'h00, b};
         default: begin
            q = a / {8'h00, b};
            r = a % {8'h00, b};
            return {r[7:0], q[7:0]};
         end
      endcase
   endfunction

   function automatic logic [7:0] f_byte(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b, input int i);
      logic [7:0] seq [3];
      if (op == 2'd3) begin
         seq[0] = a[15:8]; seq[1] = a[7:0]; seq[2] = b;
      end else begin
         seq[0] = a[7:0]; seq[1] = b; seq[2] = b;
      end
      return seq[i];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at cycle %0d: wait bound expired", name, cyc);
   endtask

   // Behavioural model: phase and cycles-since-accept, advanced on every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_phase  = PH_NR;
            m_alu_op = '0;
         end else begin
            case (m_phase)
               PH_NR: m_phase = PH_IDLE;
               PH_IDLE: begin
                  if (bus.cmd_valid) begin
                     m_op      = bus.cmd_op;
                     m_a       = bus.cmd_a;
                     m_b       = bus.cmd_b;
                     m_alu_op  = bus.cmd_op;
                     m_t       = 0;
                     m_phase   = PH_BUSY;
                     m_acc_cnt++;
                     m_acc_cyc = cyc;
                  end
               end
               PH_BUSY: begin
                  m_t++;
                  if (m_t == f_total(m_op)) begin
                     m_phase = PH_RESP;
                     m_res   = f_res(m_op, m_a, m_b);
                  end
               end
               PH_RESP: if (bus.res_ready) m_phase = PH_IDLE;
               default: ;
            endcase
         end
      end
   end

   // ALU_2 stand-in: result bytes are visible only in the cycle ending on their sample edge.
   initial begin
      bus.alu_outbus = '0;
      bus.res_ready  = 1'b1;
      forever begin
         @(negedge clk);
         bus.res_ready = (rr_mode == 2) ? 1'b1 : ((rr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
         bus.alu_outbus = 8'($urandom);
         if (m_phase == PH_BUSY) begin
            int s1;
            logic [15:0] r;
            s1 = 1 + f_nb(m_op) * BC + f_lat(m_op);
            r  = f_res(m_op, m_a, m_b);
            if (m_t == s1 - 1)
               bus.alu_outbus = (m_op >= 2'd2) ? r[15:8] : r[7:0];
            else if (m_op >= 2'd2 && m_t == s1 + OC - 1)
               bus.alu_outbus = r[7:0];
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (m_phase != PH_OFF) begin
            logic       e_ready, e_valid, e_begin, e_rst;
            logic [7:0] e_in;
            int         tot, nbc;
            e_ready = (m_phase == PH_IDLE);
            e_valid = (m_phase == PH_RESP);
            e_begin = 1'b0;
            e_rst   = 1'b0;
            e_in    = '0;
            if (m_phase == PH_BUSY) begin
               tot     = f_total(m_op);
               nbc     = f_nb(m_op) * BC;
               e_begin = (m_t <= tot - 2);
               e_rst   = (m_t == 0);
               if (m_t >= 1 && m_t <= nbc)
                  e_in = f_byte(m_op, m_a, m_b, (m_t - 1) / BC);
               else if (m_t > nbc && m_t <= tot - 2)
                  e_in = f_byte(m_op, m_a, m_b, f_nb(m_op) - 1);
            end
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_ready));
            chk("res_valid", 32'(bus.res_valid), 32'(e_valid));
            chk("alu_begin", 32'(bus.alu_begin), 32'(e_begin));
            chk("alu_rst", 32'(bus.alu_rst), 32'(e_rst));
            chk("alu_op", 32'(bus.alu_op), 32'(m_alu_op));
            chk("alu_inbus", 32'(bus.alu_inbus), 32'(e_in));
            if (m_phase == PH_NR)   chk("res_data_rst", 32'(bus.res_data), 32'h0);
            if (m_phase == PH_RESP) chk("res_data", 32'(bus.res_data), 32'(m_res));
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b);
      int  c0;
      bit  ok;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      c0 = m_acc_cnt;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (m_acc_cnt != c0) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("accept");
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_a     = 16'($urandom);
      bus.cmd_b     = 8'($urandom);
   endtask

   task automatic wait_res(input string name, input int lat, input logic [15:0] exp);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus.res_valid === 1'b1) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) timeout(name);
      else begin
         if (lat > 0) chk({name, "_lat"}, 32'(cyc - m_acc_cyc), 32'(lat));
         chk({name, "_data"}, 32'(bus.res_data), 32'(exp));
      end
   endtask

   task automatic wait_phase(input int ph);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (m_phase == ph) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) timeout("phase");
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      rst           = 1'b1;
      rr_mode       = 2;

      chk("model_add", 32'(f_res(2'd0, 16'd24, 8'd31)), 32'h0037);
      chk("model_sub", 32'(f_res(2'd1, 16'd99, 8'd55)), 32'h002C);
      chk("model_mul", 32'(f_res(2'd2, 16'd32, 8'd25)), 32'h0320);
      chk("model_div", 32'(f_res(2'd3, 16'h0999, 8'd25)), 32'h0762);
      chk("model_tot_add", 32'(f_total(2'd0)), 32'd14);
      chk("model_tot_mul", 32'(f_total(2'd2)), 32'd87);
      chk("model_tot_div", 32'(f_total(2'd3)), 32'd89);

      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("ready_after_rst", 32'(bus.cmd_ready), 32'h1);

      send(2'd0, 16'd24, 8'd31);
      wait_res("add", 14, 16'h0037);
      wait_phase(PH_IDLE);
      send(2'd1, 16'd99, 8'd55);
      wait_res("sub", 14, 16'h002C);
      wait_phase(PH_IDLE);
      send(2'd2, 16'd32, 8'd25);
      wait_res("mul", 87, 16'h0320);
      wait_phase(PH_IDLE);
      send(2'd3, 16'h0999, 8'd25);
      wait_res("div", 89, 16'h0762);
      wait_phase(PH_IDLE);

      // Result held under backpressure while another command waits.
      rr_mode = 1;
      send(2'd0, 16'd24, 8'd31);
      wait_res("bp_add", 14, 16'h0037);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd1;
      bus.cmd_a     = 16'd99;
      bus.cmd_b     = 8'd55;
      repeat (20) begin
         tick();
         chk("bp_hold", 32'(bus.res_data), 32'h0037);
         chk("bp_ready", 32'(bus.cmd_ready), 32'h0);
      end
      rr_mode = 2;
      send(2'd1, 16'd99, 8'd55);
      wait_res("bp_sub", 14, 16'h002C);
      wait_phase(PH_IDLE);

      // Abort a multiply in its latency wait.
      send(2'd2, 16'd32, 8'd25);
      for (int i = 0; i < 100 && !(m_phase == PH_BUSY && m_t == 40); i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_begin", 32'(bus.alu_begin), 32'h0);
      chk("abort_rst", 32'(bus.alu_rst), 32'h0);
      chk("abort_valid", 32'(bus.res_valid), 32'h0);
      tick();
      chk("abort_ready", 32'(bus.cmd_ready), 32'h1);
      send(2'd0, 16'd24, 8'd31);
      wait_res("abort_add", 14, 16'h0037);
      wait_phase(PH_IDLE);

      rr_mode = 0;
      for (int n = 0; n < 30; n++) begin
         logic [1:0]  op;
         logic [15:0] a;
         logic [7:0]  b;
         op = 2'($urandom_range(0, 3));
         a  = 16'($urandom);
         b  = 8'($urandom);
         if (op == 2'd3 && b == 8'd0) b = 8'd1;
         repeat ($urandom_range(0, 3)) tick();
         send(op, a, b);
         wait_phase(PH_RESP);
      end
      rr_mode = 2;
      wait_phase(PH_IDLE);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
